// File: rtl/fifo_burst_reader.sv
// Drains a syncfifo in fixed-length bursts and re-presents the words as a valid/ready stream.
// A 2-entry buffer absorbs the FIFO's one-cycle registered read latency so reads can issue back-to-back.
`ifndef WIDTH
`define WIDTH 8
`endif

module fifo_burst_reader #(
    parameter int WIDTH     = `WIDTH,
    parameter int BURST_LEN = 16,
    parameter int CNT_W     = $clog2(BURST_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fifo_empty,
    input  logic             fifo_empty_th,
    input  logic [WIDTH-1:0] fifo_dout,
    output logic             fifo_rd_en,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    output logic             m_last,
    input  logic             m_ready,
    output logic             busy,
    output logic [15:0]      burst_cnt
);

    // state  | meaning
    // IDLE   | waiting for the FIFO to rise above its empty threshold
    // BURST  | issuing reads until BURST_LEN have been sent
    // DRAIN  | no reads; waiting for the tagged last word to be accepted
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_rd_cnt;
    logic [15:0]      r_burst_cnt;
    logic             r_busy;
    logic             r_inflight;
    logic             r_inflight_last;
    logic [1:0]       r_ob_cnt;
    logic [WIDTH-1:0] r_head_data;
    logic             r_head_last;
    logic [WIDTH-1:0] r_tail_data;
    logic             r_tail_last;

    logic             w_pop;
    logic [2:0]       w_occ;
    logic [2:0]       w_limit;
    logic             w_rd_en;
    logic             w_rd_last;

    // A same-cycle pop frees a slot, so it raises the occupancy limit rather than being subtracted.
    assign w_pop     = (r_ob_cnt != 2'd0) && m_ready;
    assign w_occ     = {1'b0, r_ob_cnt} + {2'b00, r_inflight};
    assign w_limit   = 3'd2 + {2'b00, w_pop};
    assign w_rd_en   = (r_state == ST_BURST) && !fifo_empty && (w_occ < w_limit);
    assign w_rd_last = w_rd_en && (r_rd_cnt == CNT_W'(BURST_LEN - 1));

    assign fifo_rd_en = w_rd_en;
    assign m_valid    = (r_ob_cnt != 2'd0);
    assign m_data     = r_head_data;
    assign m_last     = r_head_last;
    assign busy       = r_busy;
    assign burst_cnt  = r_burst_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_rd_cnt    <= '0;
            r_burst_cnt <= '0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!fifo_empty_th) begin
                        r_state  <= ST_BURST;
                        r_rd_cnt <= '0;
                        r_busy   <= 1'b1;
                    end
                end
                ST_BURST: begin
                    if (w_rd_en) begin
                        r_rd_cnt <= r_rd_cnt + CNT_W'(1);
                        if (w_rd_last) begin
                            r_state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_pop && r_head_last) begin
                        r_state     <= ST_IDLE;
                        r_busy      <= 1'b0;
                        r_burst_cnt <= r_burst_cnt + 16'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_ob_cnt        <= 2'd0;
            r_head_data     <= '0;
            r_head_last     <= 1'b0;
            r_tail_data     <= '0;
            r_tail_last     <= 1'b0;
        end else begin
            r_inflight      <= w_rd_en;
            r_inflight_last <= w_rd_last;
            case ({r_inflight, w_pop})
                2'b11: begin
                    if (r_ob_cnt == 2'd2) begin
                        r_head_data <= r_tail_data;
                        r_head_last <= r_tail_last;
                        r_tail_data <= fifo_dout;
                        r_tail_last <= r_inflight_last;
                    end else begin
                        r_head_data <= fifo_dout;
                        r_head_last <= r_inflight_last;
                    end
                end
                2'b10: begin
                    if (r_ob_cnt == 2'd0) begin
                        r_head_data <= fifo_dout;
                        r_head_last <= r_inflight_last;
                    end else begin
                        r_tail_data <= fifo_dout;
                        r_tail_last <= r_inflight_last;
                    end
                    r_ob_cnt <= r_ob_cnt + 2'd1;
                end
                2'b01: begin
                    r_head_data <= r_tail_data;
                    r_head_last <= r_tail_last;
                    r_ob_cnt    <= r_ob_cnt - 2'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: behavioural syncfifo model feeding the DUT, scoreboard of written words
// checked in order at the stream output, plus stall-stability and read-on-empty monitors.
module tb_fifo_burst_reader;
    localparam int W  = 8;
    localparam int BL = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         fifo_empty = 1'b1;
    logic         fifo_empty_th = 1'b1;
    logic [W-1:0] fifo_dout = '0;
    logic         fifo_rd_en;
    logic [W-1:0] m_data;
    logic         m_valid;
    logic         m_last;
    logic         m_ready = 1'b0;
    logic         busy;
    logic [15:0]  burst_cnt;

    fifo_burst_reader #(.WIDTH(W), .BURST_LEN(BL)) dut (
        .clk(clk), .rst_n(rst_n),
        .fifo_empty(fifo_empty), .fifo_empty_th(fifo_empty_th), .fifo_dout(fifo_dout),
        .fifo_rd_en(fifo_rd_en),
        .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
        .busy(busy), .burst_cnt(burst_cnt)
    );

    always #5 clk = ~clk;

    logic [W-1:0] fifo_q[$];
    logic [W:0]   exp_q[$];
    int th_level = 100;
    int wr_idx, n_vec, n_err, n_rd, n_pop, n_last, run, max_run, cyc, first_rd, first_v;
    bit rnd_ready;
    bit prev_stall;
    logic [W-1:0] prev_data;
    logic prev_last;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // syncfifo model: registered read data, flags updated at the clock edge
    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            fifo_dout <= '0;
        end else if (fifo_rd_en) begin
            n_rd++;
            if (fifo_q.size() > 0) fifo_dout <= fifo_q.pop_front();
        end
        fifo_empty    <= (fifo_q.size() == 0);
        fifo_empty_th <= (fifo_q.size() <= th_level);
    end

    always @(negedge clk) begin
        logic [W:0] e;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (fifo_empty) chk("rd_on_empty", 32'(fifo_rd_en), 0);
            if (prev_stall) begin
                chk("hold_valid", 32'(m_valid), 1);
                chk("hold_data", 32'(m_data), 32'(prev_data));
                chk("hold_last", 32'(m_last), 32'(prev_last));
            end
            if (fifo_rd_en) begin
                run++;
                if (run > max_run) max_run = run;
                if (first_rd < 0) first_rd = cyc;
            end else begin
                run = 0;
            end
            if (m_valid && first_v < 0) first_v = cyc;
            if (m_valid && m_ready) begin
                n_pop++;
                if (m_last) n_last++;
                if (exp_q.size() == 0) begin
                    chk("sb_underflow", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("data", 32'(m_data), 32'(e[W-1:0]));
                    chk("last", 32'(m_last), 32'(e[W]));
                end
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_ready) m_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        rnd_ready = 1'b0;
        m_ready = 1'b0;
        fifo_q.delete();
        exp_q.delete();
        wr_idx = 0;
        th_level = 100;
        cycles(2);
        n_rd = 0; n_pop = 0; n_last = 0; run = 0; max_run = 0; first_rd = -1; first_v = -1;
        rst_n = 1'b1;
        cycles(1);
    endtask

    task automatic push(input int n);
        for (int i = 0; i < n; i++) begin
            fifo_q.push_back(W'(wr_idx));
            exp_q.push_back({(wr_idx % BL) == BL - 1, W'(wr_idx)});
            wr_idx++;
        end
    endtask

    task automatic wait_busy(input int budget);
        int k = 0;
        while (!busy && k < budget) begin cycles(1); k++; end
        chk("wait_busy", 32'(busy), 1);
    endtask

    task automatic wait_valid(input int budget);
        int k = 0;
        while (!m_valid && k < budget) begin cycles(1); k++; end
        chk("wait_valid", 32'(m_valid), 1);
    endtask

    task automatic wait_bursts(input int n, input int budget);
        int k = 0;
        while (int'(burst_cnt) != n && k < budget) begin cycles(1); k++; end
        chk("wait_bursts", 32'(burst_cnt), n);
    endtask

    initial begin
        int k;
        do_reset();
        chk("rst_valid", 32'(m_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_bcnt", 32'(burst_cnt), 0);
        chk("rst_rden", 32'(fifo_rd_en), 0);

        // basic burst
        push(10);
        cycles(2);
        m_ready = 1'b1;
        th_level = -1;
        wait_busy(20);
        th_level = 100;
        wait_bursts(1, 100);
        chk("basic_busy", 32'(busy), 0);
        chk("basic_reads", n_rd, 4);
        chk("basic_run", max_run, 4);
        chk("basic_pops", n_pop, 4);
        chk("basic_lasts", n_last, 1);
        chk("basic_latency", first_v - first_rd, 2);
        cycles(5);
        chk("basic_no_restart", n_rd, 4);

        // backpressure
        do_reset();
        push(10);
        cycles(2);
        th_level = -1;
        wait_busy(20);
        th_level = 100;
        wait_valid(20);
        for (int i = 0; i < 6; i++) begin
            chk("bp_head", 32'(m_data), 0);
            cycles(1);
        end
        chk("bp_reads", n_rd, 2);
        m_ready = 1'b1;
        wait_bursts(1, 100);
        chk("bp_pops", n_pop, 4);

        // FIFO empties mid-burst
        do_reset();
        push(2);
        m_ready = 1'b1;
        th_level = -1;
        cycles(12);
        chk("em_reads", n_rd, 2);
        chk("em_pops", n_pop, 2);
        chk("em_busy", 32'(busy), 1);
        chk("em_bcnt", 32'(burst_cnt), 0);
        push(2);
        wait_bursts(1, 100);
        chk("em_pops2", n_pop, 4);
        chk("em_lasts", n_last, 1);

        // back-to-back bursts
        do_reset();
        push(512);
        m_ready = 1'b1;
        th_level = -1;
        wait_bursts(128, 4000);
        chk("b2b_pops", n_pop, 512);
        chk("b2b_lasts", n_last, 128);
        chk("b2b_left", exp_q.size(), 0);

        // random consumer backpressure
        do_reset();
        push(512);
        th_level = -1;
        rnd_ready = 1'b1;
        wait_bursts(128, 8000);
        rnd_ready = 1'b0;
        chk("rnd_pops", n_pop, 512);
        chk("rnd_lasts", n_last, 128);

        // reset mid-burst
        do_reset();
        push(10);
        m_ready = 1'b1;
        th_level = -1;
        k = 0;
        while (n_pop < 2 && k < 100) begin @(negedge clk); #1; k++; end
        chk("rm_wait", n_pop, 2);
        chk("rm_pre_busy", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("rm_valid", 32'(m_valid), 0);
        chk("rm_last", 32'(m_last), 0);
        chk("rm_data", 32'(m_data), 0);
        chk("rm_rden", 32'(fifo_rd_en), 0);
        chk("rm_busy", 32'(busy), 0);
        chk("rm_bcnt", 32'(burst_cnt), 0);
        fifo_q.delete();
        exp_q.delete();
        th_level = 100;
        cycles(2);
        rst_n = 1'b1;
        cycles(3);
        chk("rm_post_busy", 32'(busy), 0);
        chk("rm_post_bcnt", 32'(burst_cnt), 0);
        chk("rm_post_valid", 32'(m_valid), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/fifo_burst_reader.md
# fifo_burst_reader

Downstream drain stage for `syncfifo`. It watches the FIFO's `empty`/`empty_th` flags, issues `rd_en` in bursts of `BURST_LEN` words, and absorbs the FIFO's one-cycle registered read latency in a 2-entry output buffer. It presents the words as a valid/ready stream to the consumer, marking the last word of each burst.

## Interface
- `WIDTH`, default `` `WIDTH`` (from `defines.sv`): data width, identical to the FIFO's.
- `BURST_LEN`, default 16: words per burst, at least 2.
- `CNT_W`, default `$clog2(BURST_LEN+1)`: width of the internal read counter.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `fifo_empty`  in  1  FIFO `empty`.
- `fifo_empty_th`  in  1  FIFO `empty_th`; high while occupancy is at or below the empty threshold.
- `fifo_dout`  in  WIDTH  FIFO `data_out`; valid in the cycle after an `rd_en` edge.
- `fifo_rd_en`  out  1  FIFO `rd_en`.
- `m_data`  out  WIDTH  output word (buffer head).
- `m_valid`  out  1  `m_data` is valid.
- `m_last`  out  1  `m_data` is the final word of a burst; qualified by `m_valid`.
- `m_ready`  in  1  consumer accepts the word.
- `busy`  out  1  high in any state other than IDLE.
- `burst_cnt`  out  16  number of completed bursts, wraps modulo 2^16.

## Operation
FSM states:
- **IDLE**
  - Go to BURST when `fifo_empty_th` = 0 is sampled at a clock edge.
  - Clear `rd_cnt` on the transition.
- **BURST**
  - `fifo_rd_en = !fifo_empty && (ob_cnt + inflight - pop) < 2`.
    - `pop = m_valid & m_ready`.
    - `inflight` = 1 when `fifo_rd_en` was high in the previous cycle.
    - `fifo_rd_en` is combinational from registered state and inputs, including `m_ready`.
  - Every issued read increments `rd_cnt`. The read with `rd_cnt == BURST_LEN-1` is tagged "last".
  - After that last read is issued, go to DRAIN.
  - If the FIFO empties mid-burst, reads stall and the burst continues when data returns. A burst is never shortened.
- **DRAIN**
  - No reads.
  - When the tagged word is popped, increment `burst_cnt` and go to IDLE.
- **Output buffer**
  - 2-entry FIFO of {data, last}, with registered outputs.
  - Captures `fifo_dout` plus the tag at the edge following the read's issue edge.
  - Pop and capture in the same cycle are allowed.
- **Safety invariants**
  - `fifo_rd_en` is never high while `fifo_empty` = 1.
  - `ob_cnt` never exceeds 2.
  - No word is lost or duplicated.
  - Words leave in FIFO order.
- **Reset**
  - Asynchronous assertion forces IDLE and clears `rd_cnt`, `ob_cnt`, `inflight` and `burst_cnt`.
  - Outputs go to `fifo_rd_en`=0, `m_valid`=0, `m_last`=0, `m_data`=0, `busy`=0, `burst_cnt`=0.
  - Reset mid-burst discards buffered and in-flight words. The FIFO is expected to be reset together with this block.

## Timing
- IDLE→BURST: one edge after `fifo_empty_th` is sampled low. `fifo_rd_en` can go high in the first BURST cycle.
- Read latency:
  - `fifo_rd_en` is sampled at edge N.
  - `fifo_dout` is valid between edges N and N+1 and is captured at edge N+1.
  - `m_valid` rises after edge N+1, i.e. two edges after the read.
- Throughput: with `m_ready` held at 1, one word per cycle, gap-free.
  - First `m_valid` follows the first read by 2 cycles.
  - A burst of `BURST_LEN` words occupies `BURST_LEN` consecutive `m_valid` cycles.
- Backpressure: when `m_ready` = 0, at most 2 words are buffered, and `fifo_rd_en` drops once `ob_cnt + inflight` = 2.
- Stream rules:
  - `m_data`, `m_last` and `m_valid` stay stable while `m_valid & !m_ready`.
  - `m_valid` is not withdrawn until the word is accepted.
- `burst_cnt` and `busy` update at the edge where the last word is popped. A new burst needs at least one IDLE cycle.

## Test plan
- **Basic burst** (BURST_LEN=4, WIDTH=8): preload 0..9, drop `fifo_empty_th`, `m_ready`=1.
  - Expect `fifo_rd_en` high for 4 consecutive cycles.
  - Expect `m_data` 0,1,2,3 on consecutive cycles, with `m_last` only on 3.
  - Expect `burst_cnt`=1, then `busy`=0.
- **Backpressure**: same stimulus with `m_ready`=0 for 6 cycles after the first `m_valid`.
  - Expect exactly 2 reads issued, then stall.
  - `m_data`=0 held; order preserved after release; no duplicates.
- **Empty mid-burst**: FIFO holds 2 words and `fifo_empty_th` is forced low.
  - Expect words 0,1, then `fifo_rd_en`=0 while `fifo_empty`=1.
  - After 2 more writes, words 2,3 with `m_last` on 3.
- **Back-to-back bursts**: 512 words preloaded, `m_ready`=1.
  - Expect 128 bursts, `burst_cnt`=128, data 0..511 in order.
  - Exactly 128 `m_last` pulses, each every 4th word.
- **Random `m_ready`** (50%) over 512 words: the scoreboard matches FIFO order, and `fifo_rd_en & fifo_empty` never occurs.
- **Reset mid-burst**: assert `rst_n`=0 after the 2nd output word.
  - All outputs read 0 immediately, with no edge needed.
  - After release, `burst_cnt`=0 and the state is IDLE.
